// File: rtl/fpalu_dotseq.sv
`default_nettype none
// ============================================================================
// Module   : fpalu_dotseq
// Purpose  : Dot-product sequencer; issues MUL16i then ADD29i per tap to the
//            shared FPALU. Optional macro FPALU_DOTSEQ_PERF_EN adds perf_cyc.
// Revision : 1.0
// ============================================================================
module fpalu_dotseq #(
   parameter int ALU_LAT = 1,
   parameter int DADDR_W = 9,
   parameter int CADDR_W = 6,
   parameter int LEN_W   = 6
) (
`ifdef FPALU_DOTSEQ_PERF_EN
   output logic [15:0]        perf_cyc,
`endif
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic [DADDR_W-1:0] dbase,
   input  logic [CADDR_W-1:0] cbase,
   output logic               busy,
   output logic               done,
   output logic               res_sgn,
   output logic [5:0]         res_exp,
   output logic [21:0]        res_man_dn,
   output logic [DADDR_W-1:0] daddr,
   input  logic [15:0]        din,
   output logic [CADDR_W-1:0] caddr,
   input  logic [15:0]        cin,
   output logic [1:0]         alu_opcode,
   output logic               alu_a_sgn,
   output logic [5:0]         alu_a_exp,
   output logic [21:0]        alu_a_man_dn,
   output logic               alu_b_sgn,
   output logic [5:0]         alu_b_exp,
   output logic [21:0]        alu_b_man_dn,
   input  logic               alu_y_sgn,
   input  logic [5:0]         alu_y_exp,
   input  logic [21:0]        alu_y_man_dn
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ADD  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   typedef struct packed {
      logic        sgn;
      logic [5:0]  exp;
      logic [21:0] man;
   } uni_t;

   localparam int              PH_W    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(ALU_LAT);
   localparam logic [1:0]      OP_IDLE = 2'b00;
   localparam logic [1:0]      OP_MUL  = 2'b10;
   localparam logic [1:0]      OP_ADD  = 2'b11;

   state_t             state_q, state_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [DADDR_W-1:0] daddr_q, daddr_d;
   logic [CADDR_W-1:0] caddr_q, caddr_d;
   uni_t               acc_q, acc_d;
   uni_t               prod_q, prod_d;
   uni_t               res_q, res_d;
   uni_t               hold_a_q, hold_a_d;
   uni_t               hold_b_q, hold_b_d;
   logic               done_q, done_d;
   uni_t               w_a, w_b, w_y;
   logic [1:0]         w_op;
   logic               w_last;

   // FP16 -> unified format: exponent rebias by +10, mantissa right-justified
   function automatic uni_t fmt16(input logic [15:0] h);
      uni_t u;
      u.sgn = h[15];
      u.exp = {1'b0, h[14:10]} + 6'd10;
      u.man = {12'b0, h[9:0]};
      return u;
   endfunction

   assign w_y    = {alu_y_sgn, alu_y_exp, alu_y_man_dn};
   assign w_last = (phase_q == PH_LAST);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      rem_d    = rem_q;
      daddr_d  = daddr_q;
      caddr_d  = caddr_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      res_d    = res_q;
      done_d   = 1'b0;
      w_op     = OP_IDLE;
      w_a      = hold_a_q;
      w_b      = hold_b_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rem_d   = len;
               daddr_d = dbase;
               caddr_d = cbase;
               acc_d   = '0;
               phase_d = '0;
               state_d = (len == '0) ? S_FIN : S_MUL;
            end
         end
         S_MUL: begin
            w_op = OP_MUL;
            w_a  = fmt16(din);
            w_b  = fmt16(cin);
            if (w_last) begin
               prod_d  = w_y;
               daddr_d = daddr_q + DADDR_W'(1);
               caddr_d = caddr_q + CADDR_W'(1);
               phase_d = '0;
               state_d = S_ADD;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         S_ADD: begin
            w_op = OP_ADD;
            w_a  = prod_q;
            w_b  = acc_q;
            if (w_last) begin
               acc_d   = w_y;
               rem_d   = rem_q - LEN_W'(1);
               phase_d = '0;
               state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_MUL;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         default: begin
            res_d   = acc_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
      // Operands outside MUL/ADD replay whatever was last driven
      hold_a_d = w_a;
      hold_b_d = w_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         rem_q    <= '0;
         daddr_q  <= '0;
         caddr_q  <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         res_q    <= '0;
         hold_a_q <= '0;
         hold_b_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         rem_q    <= rem_d;
         daddr_q  <= daddr_d;
         caddr_q  <= caddr_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         res_q    <= res_d;
         hold_a_q <= hold_a_d;
         hold_b_q <= hold_b_d;
         done_q   <= done_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign daddr      = daddr_q;
   assign caddr      = caddr_q;
   assign alu_opcode = w_op;
   assign {res_sgn, res_exp, res_man_dn}       = res_q;
   assign {alu_a_sgn, alu_a_exp, alu_a_man_dn} = w_a;
   assign {alu_b_sgn, alu_b_exp, alu_b_man_dn} = w_b;

`ifdef FPALU_DOTSEQ_PERF_EN
   logic [15:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (busy && (perf_q != 16'hFFFF)) begin
         perf_d = perf_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cyc = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpalu_dotseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpalu_dotseq
// Purpose  : Directed bench for fpalu_dotseq at ALU_LAT=1 and ALU_LAT=3 with a
//            pipelined stub FPALU and combinational FP16 memories.
// Revision : 1.0
// ============================================================================
module tb_fpalu_dotseq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic [15:0] dmem [512];
   logic [15:0] cmem [64];

   logic        st1 = 1'b0, st3 = 1'b0;
   logic [5:0]  len = '0;
   logic [8:0]  dbase = '0;
   logic [5:0]  cbase = '0;

   logic        busy1, done1, busy3, done3;
   logic [28:0] res1, res3, a1, b1, a3, b3;
   logic [28:0] y1 = '0;
   logic [28:0] p3 [3];
   logic [28:0] y3;
   logic [8:0]  daddr1, daddr3;
   logic [5:0]  caddr1, caddr3;
   logic [15:0] din1, cin1, din3, cin3;
   logic [1:0]  op1, op3;
`ifdef FPALU_DOTSEQ_PERF_EN
   logic [15:0] perf1, perf3;
`endif

   assign din1 = dmem[daddr1];
   assign cin1 = cmem[caddr1];
   assign din3 = dmem[daddr3];
   assign cin3 = cmem[caddr3];

   // Stub FPALU: deliberately simple, hand-traceable arithmetic
   function automatic logic [28:0] alu_f(input logic [1:0] op, input logic [28:0] a,
                                         input logic [28:0] b);
      logic [28:0] y;
      y = '0;
      if (op == 2'b10) begin
         y = {a[28] ^ b[28], 6'(a[27:22] + b[27:22] - 6'd15), 22'(a[21:0] + b[21:0])};
      end else if (op == 2'b11) begin
         y = {a[28] | b[28], a[27:22] ^ b[27:22], 22'(a[21:0] + b[21:0] + 22'd1)};
      end
      return y;
   endfunction

   always @(posedge clk) y1 <= alu_f(op1, a1, b1);
   always @(posedge clk) begin
      p3[0] <= alu_f(op3, a3, b3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign y3 = p3[2];

   fpalu_dotseq #(.ALU_LAT(1), .DADDR_W(9), .CADDR_W(6), .LEN_W(6)) dut1 (
`ifdef FPALU_DOTSEQ_PERF_EN
      .perf_cyc(perf1),
`endif
      .clk(clk), .rst_n(rst_n), .start(st1), .len(len), .dbase(dbase), .cbase(cbase),
      .busy(busy1), .done(done1),
      .res_sgn(res1[28]), .res_exp(res1[27:22]), .res_man_dn(res1[21:0]),
      .daddr(daddr1), .din(din1), .caddr(caddr1), .cin(cin1), .alu_opcode(op1),
      .alu_a_sgn(a1[28]), .alu_a_exp(a1[27:22]), .alu_a_man_dn(a1[21:0]),
      .alu_b_sgn(b1[28]), .alu_b_exp(b1[27:22]), .alu_b_man_dn(b1[21:0]),
      .alu_y_sgn(y1[28]), .alu_y_exp(y1[27:22]), .alu_y_man_dn(y1[21:0])
   );

   fpalu_dotseq #(.ALU_LAT(3), .DADDR_W(9), .CADDR_W(6), .LEN_W(6)) dut3 (
`ifdef FPALU_DOTSEQ_PERF_EN
      .perf_cyc(perf3),
`endif
      .clk(clk), .rst_n(rst_n), .start(st3), .len(len), .dbase(dbase), .cbase(cbase),
      .busy(busy3), .done(done3),
      .res_sgn(res3[28]), .res_exp(res3[27:22]), .res_man_dn(res3[21:0]),
      .daddr(daddr3), .din(din3), .caddr(caddr3), .cin(cin3), .alu_opcode(op3),
      .alu_a_sgn(a3[28]), .alu_a_exp(a3[27:22]), .alu_a_man_dn(a3[21:0]),
      .alu_b_sgn(b3[28]), .alu_b_exp(b3[27:22]), .alu_b_man_dn(b3[21:0]),
      .alu_y_sgn(y3[28]), .alu_y_exp(y3[27:22]), .alu_y_man_dn(y3[21:0])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // After return the bench sits in cycle k=1 (first cycle after the accept edge)
   task automatic pulse1(input logic [5:0] l, input logic [8:0] d, input logic [5:0] c);
      len = l; dbase = d; cbase = c; st1 = 1'b1;
      tick();
      st1 = 1'b0;
   endtask

   task automatic pulse3(input logic [5:0] l, input logic [8:0] d, input logic [5:0] c);
      len = l; dbase = d; cbase = c; st3 = 1'b1;
      tick();
      st3 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++;
         if ({busy1, done1, op1, daddr1, caddr1} !== 19'd0) begin
            failures++;
            $display("FAIL reset_idle1 cyc=%0d: got busy=%b done=%b op=%b da=%h ca=%h want all 0",
                     k, busy1, done1, op1, daddr1, caddr1);
         end
         checks++;
         if ({busy3, done3, op3, daddr3, caddr3} !== 19'd0) begin
            failures++;
            $display("FAIL reset_idle3 cyc=%0d: got busy=%b done=%b op=%b da=%h ca=%h want all 0",
                     k, busy3, done3, op3, daddr3, caddr3);
         end
      end
      checks++;
      if ({res1, a1, b1} !== 87'd0) begin
         failures++;
         $display("FAIL reset_data: got res=%h a=%h b=%h want 0", res1, a1, b1);
      end
`ifdef FPALU_DOTSEQ_PERF_EN
      checks++;
      if (perf3 !== 16'd0) begin
         failures++;
         $display("FAIL reset_perf: got %0d want 0", perf3);
      end
`endif
   endtask

   task automatic test_single();
      logic [1:0]  e_op;
      logic [28:0] e_a, e_b;
      pulse1(6'd1, 9'd5, 6'd3);
      for (int k = 1; k <= 7; k++) begin
         e_op = (k <= 2) ? 2'b10 : (k <= 4) ? 2'b11 : 2'b00;
         checks++;
         if (op1 !== e_op || done1 !== (k == 6) || busy1 !== (k <= 5)) begin
            failures++;
            $display("FAIL single_seq k=%0d: got op=%b done=%b busy=%b want op=%b done=%b busy=%b",
                     k, op1, done1, busy1, e_op, (k == 6), (k <= 5));
         end
         if (k <= 4) begin
            e_a = (k <= 2) ? {1'b0, 6'd25, 22'd0} : {1'b0, 6'd36, 22'd0};
            e_b = (k <= 2) ? {1'b0, 6'd26, 22'd0} : 29'd0;
            checks++;
            if (a1 !== e_a || b1 !== e_b) begin
               failures++;
               $display("FAIL single_operands k=%0d: got a=%h b=%h want a=%h b=%h",
                        k, a1, b1, e_a, e_b);
            end
         end
         if (k == 6) begin
            checks++;
            if (res1 !== {1'b0, 6'd36, 22'd1}) begin
               failures++;
               $display("FAIL single_res: got %h want %h", res1, {1'b0, 6'd36, 22'd1});
            end
         end
         tick();
      end
   endtask

   task automatic test_len_zero();
      pulse1(6'd0, 9'd5, 6'd3);
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (op1 !== 2'b00 || done1 !== (k == 2) || busy1 !== (k == 1)) begin
            failures++;
            $display("FAIL len0_seq k=%0d: got op=%b done=%b busy=%b want op=00 done=%b busy=%b",
                     k, op1, done1, busy1, (k == 2), (k == 1));
         end
         if (k == 2) begin
            checks++;
            if (res1 !== 29'd0) begin
               failures++;
               $display("FAIL len0_res: got %h want 0", res1);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      logic [8:0]  exp_da [4];
      logic [5:0]  exp_ca [4];
      logic [1:0]  e_op;
      int          ph;
      exp_da = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
      exp_ca = '{6'd10, 6'd11, 6'd12, 6'd13};
      pulse3(6'd4, 9'h1FE, 6'd10);
      for (int k = 1; k <= 35; k++) begin
         ph = (k - 1) / 4;
         e_op = (k > 32) ? 2'b00 : ((ph % 2) == 0) ? 2'b10 : 2'b11;
         checks++;
         if (op3 !== e_op || done3 !== (k == 34) || busy3 !== (k <= 33)) begin
            failures++;
            $display("FAIL wrap_seq k=%0d: got op=%b done=%b busy=%b want op=%b done=%b busy=%b",
                     k, op3, done3, busy3, e_op, (k == 34), (k <= 33));
         end
         if (e_op == 2'b10) begin
            checks++;
            if (daddr3 !== exp_da[ph / 2] || caddr3 !== exp_ca[ph / 2]) begin
               failures++;
               $display("FAIL wrap_addr k=%0d: got da=%h ca=%0d want da=%h ca=%0d",
                        k, daddr3, caddr3, exp_da[ph / 2], exp_ca[ph / 2]);
            end
         end
         if (k == 34) begin
            checks++;
            if (res3 !== {1'b1, 6'd7, 22'd5}) begin
               failures++;
               $display("FAIL wrap_res: got %h want %h", res3, {1'b1, 6'd7, 22'd5});
            end
         end
         tick();
      end
   endtask

   task automatic test_restart_ignored();
      int          n_done;
      int          ph;
      logic [8:0]  e_da;
      logic [5:0]  e_ca;
      n_done = 0;
      pulse1(6'd4, 9'd20, 6'd30);
      for (int k = 1; k <= 20; k++) begin
         if (done1 === 1'b1) n_done++;
         ph = (k - 1) / 2;
         if (k <= 16 && (ph % 2) == 0) begin
            e_da = 9'd20 + 9'(ph / 2);
            e_ca = 6'd30 + 6'(ph / 2);
            checks++;
            if (op1 !== 2'b10 || daddr1 !== e_da || caddr1 !== e_ca) begin
               failures++;
               $display("FAIL restart_addr k=%0d: got op=%b da=%0d ca=%0d want op=10 da=%0d ca=%0d",
                        k, op1, daddr1, caddr1, e_da, e_ca);
            end
         end
         if (k == 18) begin
            checks++;
            if (done1 !== 1'b1 || res1 !== {1'b0, 6'd0, 22'd4}) begin
               failures++;
               $display("FAIL restart_res: got done=%b res=%h want done=1 res=%h",
                        done1, res1, {1'b0, 6'd0, 22'd4});
            end
         end
         if (k == 3) begin
            len = 6'd1; dbase = 9'd100; cbase = 6'd1; st1 = 1'b1;
            tick();
            st1 = 1'b0;
         end else begin
            tick();
         end
      end
      checks++;
      if (n_done != 1) begin
         failures++;
         $display("FAIL restart_done_count: got %0d want 1", n_done);
      end
   endtask

   task automatic test_back_to_back();
      pulse1(6'd1, 9'd5, 6'd3);
      repeat (5) tick();
      checks++;
      if (done1 !== 1'b1 || res1 !== {1'b0, 6'd36, 22'd1}) begin
         failures++;
         $display("FAIL b2b_first: got done=%b res=%h want done=1 res=%h",
                  done1, res1, {1'b0, 6'd36, 22'd1});
      end
      pulse1(6'd0, 9'd5, 6'd3);
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy1, done1);
      end
      tick();
      checks++;
      if (done1 !== 1'b1 || res1 !== 29'd0) begin
         failures++;
         $display("FAIL b2b_second: got done=%b res=%h want done=1 res=0", done1, res1);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int n_done;
      n_done = 0;
      pulse1(6'd2, 9'd5, 6'd3);
      tick();
      tick();
      checks++;
      if (op1 !== 2'b11) begin
         failures++;
         $display("FAIL midrst_in_add: got op=%b want 11", op1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy1, done1, op1, daddr1, caddr1} !== 19'd0 || {res1, a1, b1} !== 87'd0) begin
         failures++;
         $display("FAIL midrst_async: got busy=%b done=%b op=%b da=%h ca=%h res=%h a=%h b=%h want 0",
                  busy1, done1, op1, daddr1, caddr1, res1, a1, b1);
      end
`ifdef FPALU_DOTSEQ_PERF_EN
      checks++;
      if (perf1 !== 16'd0) begin
         failures++;
         $display("FAIL midrst_perf: got %0d want 0", perf1);
      end
`endif
      repeat (3) tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done1 !== 1'b0 || busy1 !== 1'b0) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         failures++;
         $display("FAIL midrst_no_done: got %0d active cycles want 0", n_done);
      end
      pulse1(6'd1, 9'd5, 6'd3);
      repeat (5) tick();
      checks++;
      if (done1 !== 1'b1 || res1 !== {1'b0, 6'd36, 22'd1}) begin
         failures++;
         $display("FAIL midrst_rerun: got done=%b res=%h want done=1 res=%h",
                  done1, res1, {1'b0, 6'd36, 22'd1});
      end
`ifdef FPALU_DOTSEQ_PERF_EN
      checks++;
      if (perf1 !== 16'd5) begin
         failures++;
         $display("FAIL midrst_perf_count: got %0d want 5", perf1);
      end
`endif
      tick();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) dmem[i] = 16'h0000;
      for (int i = 0; i < 64; i++) cmem[i] = 16'h0000;
      dmem[5]     = 16'h3C00;
      cmem[3]     = 16'h4000;
      dmem[9'h1FE] = 16'h3C00;
      dmem[9'h1FF] = 16'hBC00;
      dmem[9'h000] = 16'h3C01;
      dmem[9'h001] = 16'h4000;
      for (int i = 10; i < 14; i++) cmem[i] = 16'h3C00;

      test_reset();
      test_single();
      test_len_zero();
      test_wrap();
      test_restart_ignored();
      test_back_to_back();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpalu_dotseq.md
Name: fpalu_dotseq

Overview:
- Sequencer that drives the shared FPALU through a dot-product loop: result = sum over i of dmem[dbase+i] * cmem[cbase+i].
- Fetches FP16 words from the data and coefficient memories, which have combinational read ports (addr to q).
- Formats each pair into the unified operand format {sgn, exp[5:0], man_dn[21:0]}, then issues a MUL16i followed by an ADD29i into a running accumulator.
- Sits between the control path (start/length/base addresses) and the FPALU; it is the only FPALU master while busy.

Parameters:
- ALU_LAT, 1, cycles from the edge that first presents opcode/operands to the edge where dout_uni_y_* is valid (0 = combinational).
- DADDR_W, 9, dmem address width.
- CADDR_W, 6, cmem address width.
- LEN_W, 6, tap-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- len  in  LEN_W  number of taps; sampled with start.
- dbase  in  DADDR_W  first dmem address; sampled with start.
- cbase  in  CADDR_W  first cmem address; sampled with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.
- res_sgn / res_exp / res_man_dn  out  1/6/22  accumulated result; held until the next start.
- daddr  out  DADDR_W  dmem read address.
- din  in  16  dmem FP16 read data.
- caddr  out  CADDR_W  cmem read address.
- cin  in  16  cmem FP16 read data.
- alu_opcode  out  2  2'b10 = MUL16i, 2'b11 = ADD29i, 2'b00 = idle.
- alu_a_sgn/exp/man_dn, alu_b_sgn/exp/man_dn  out  1/6/22 each  FPALU operands.
- alu_y_sgn/exp/man_dn  in  1/6/22  FPALU result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, alu_opcode=2'b00; all operand, address and result outputs 0.
- States: IDLE, MUL, ADD, FIN.
- IDLE, start=1:
  - latch len/dbase/cbase; daddr=dbase, caddr=cbase; accumulator (acc) = all-zero {0,0,0}.
  - next state MUL, or FIN if len==0.
- Each op phase lasts exactly ALU_LAT+1 cycles, tracked by a phase counter.
  - Opcode and operands are held stable for the whole phase.
  - The result is captured on the last edge of the phase.
- MUL phase:
  - opcode 2'b10.
  - a = {din[15], {1'b0,din[14:10]}+6'd10, {12'b0,din[9:0]}}.
  - b is formed the same way from cin.
  - End of phase: product register <= alu_y_*; daddr+1, caddr+1 (modulo 2^width, wrap silently); go to ADD.
- ADD phase:
  - opcode 2'b11; a = product register, b = acc.
  - End of phase: acc <= alu_y_*; remaining-tap counter -1.
  - Go to MUL if taps remain, else FIN.
- FIN (one cycle): res_* <= acc, done=1, busy=0 next; go to IDLE.
- Latency: done is high exactly 2*(ALU_LAT+1)*len + 2 cycles after the edge that accepted start; len==0 gives 2 cycles.
- start while busy or in FIN: ignored, no effect on the running job.
- start in the same cycle done is high: accepted, because done is issued from FIN, not IDLE.
- Reset mid-job: immediate return to IDLE with reset values; no done pulse; res_* cleared.
- alu_opcode is 2'b00 and operands are held at their last values whenever not in MUL/ADD.

Optional Feature:
- Macro FPALU_DOTSEQ_PERF_EN.
- Defined: adds output perf_cyc (16 bits).
  - Counts cycles with busy=1 since reset; saturates at 16'hFFFF.
  - Not cleared by start.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, no start, 20 cycles -> busy=0, done=0, alu_opcode=00, daddr=0, caddr=0 throughout.
- ALU_LAT=1, len=1, dbase=5, cbase=3, dmem[5]=16'h3C00, cmem[3]=16'h4000 ->
  - MUL for 2 cycles with a_exp=25, a_man_dn=0, b_exp=26.
  - ADD for 2 cycles with b = 0.
  - done exactly 6 cycles after start; res_* equals the ADD-phase alu_y_* from a stub ALU.
- len=0 -> no MUL/ADD opcodes issued; done 2 cycles after start; res_* = 0.
- ALU_LAT=3, len=4, dbase=9'h1FE -> daddr sequence 1FE, 1FF, 000, 001 (wrap).
  - Opcode pattern MUL×4 cycles, ADD×4 cycles, repeated 4 times.
  - done at cycle 34 after start.
- start pulsed again mid-job (len=4) -> ignored; exactly one done; addresses continue undisturbed.
- rst_n asserted during an ADD phase -> outputs at reset values asynchronously; no done.
  - A following start runs correctly from IDLE.
  - With FPALU_DOTSEQ_PERF_EN, perf_cyc=0 after the reset, then counts busy cycles.
